// File: rtl/cassette_rec_if.sv
// Record-buffer write port of the cassette recorder.
// The recorder drives it as master; the buffer RAM listens as slave.
interface cassette_rec_if #(
   parameter int ADDR_W = 16
);

   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_dout;
   logic              ram_wr;

   modport master (
      output ram_addr,
      output ram_dout,
      output ram_wr
   );

   modport slave (
      input ram_addr,
      input ram_dout,
      input ram_wr
   );

endinterface

// File: rtl/cassette_rec.sv
// CoCo cassette recorder: times rising edges of the DAC output,
// decodes 2400/1200 Hz periods into bits and writes bytes to a buffer.
module cassette_rec #(
   parameter int CLK_DIV   = 57,
   parameter int ADDR_W    = 16,
   parameter int MIN_US    = 200,
   parameter int THRESH_US = 625,
   parameter int MAX_US    = 1500
) (
   input  logic              clk,
   input  logic              RESET_N,
   input  logic              cas_in,
   input  logic              motor,
   input  logic              rewind,
   cassette_rec_if.master    ram,
   output logic [ADDR_W:0]   rec_len,
   output logic              full,
   output logic              active
);

   localparam int PW = $clog2(CLK_DIV + 1);
   localparam int UW = $clog2(MAX_US + 2);

   localparam logic [PW-1:0] C_TICK = PW'(CLK_DIV - 1);
   localparam logic [UW-1:0] C_MIN  = UW'(MIN_US);
   localparam logic [UW-1:0] C_THR  = UW'(THRESH_US);
   localparam logic [UW-1:0] C_MAX  = UW'(MAX_US);
   localparam logic [UW-1:0] C_GAP  = UW'(MAX_US + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_MEAS = 2'd2;

   logic              r_sync1;
   logic              r_sync2;
   logic              r_sync3;
   logic [1:0]        r_state;
   logic [PW-1:0]     r_pre;
   logic [UW-1:0]     r_us;
   logic [7:0]        r_shift;
   logic [2:0]        r_cnt;
   logic [7:0]        r_dout;
   logic              r_wr;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_len;
   logic              r_full;

   logic       w_rise;
   logic       w_meas;
   logic       w_tick;
   logic       w_gap;
   logic       w_valid;
   logic       w_bit;
   logic       w_last;
   logic       w_moff;
   logic       w_flush;
   logic [3:0] w_sh;
   logic [7:0] w_byte;
   logic [7:0] w_fbyte;
   logic       w_wr;

   assign w_rise  = r_sync2 & ~r_sync3;
   assign w_meas  = (r_state == S_MEAS);
   assign w_tick  = (r_pre == C_TICK);
   assign w_gap   = w_meas && (r_us == C_GAP);
   assign w_valid = w_meas && w_rise
                 && (r_us >= C_MIN) && (r_us <= C_MAX);
   assign w_bit   = (r_us < C_THR);
   assign w_last  = (r_cnt == 3'd7);
   assign w_moff  = ~motor;
   assign w_flush = w_moff && (r_cnt != 3'd0);
   assign w_sh    = 4'd8 - {1'b0, r_cnt};
   assign w_byte  = {w_bit, r_shift[7:1]};
   assign w_fbyte = r_shift >> w_sh;

   // rewind in the strobe clk cancels the write outright
   assign w_wr = r_wr & ~rewind;

   assign ram.ram_addr = r_addr;
   assign ram.ram_dout = r_dout;
   assign ram.ram_wr   = w_wr;
   assign rec_len      = r_len;
   assign full         = r_full;
   assign active       = w_meas;

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= cas_in;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= S_IDLE;
      end else if (w_moff) begin
         r_state <= S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: r_state <= S_ARM;
            S_ARM: begin
               if (w_rise && !rewind)
                  r_state <= S_MEAS;
            end
            S_MEAS: begin
               if (rewind || w_gap)
                  r_state <= S_ARM;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // timing only runs while measuring; a valid edge restarts it
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_pre <= '0;
         r_us  <= '0;
      end else if (!w_meas || w_valid) begin
         r_pre <= '0;
         r_us  <= '0;
      end else if (w_tick) begin
         r_pre <= '0;
         if (r_us != C_GAP)
            r_us <= r_us + 1'b1;
      end else begin
         r_pre <= r_pre + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_wr    <= 1'b0;
      end else begin
         r_wr <= 1'b0;
         if (rewind) begin
            r_shift <= '0;
            r_cnt   <= '0;
         end else if (w_moff) begin
            if (w_flush) begin
               r_shift <= '0;
               r_cnt   <= '0;
               if (!r_full) begin
                  r_dout <= w_fbyte;
                  r_wr   <= 1'b1;
               end
            end
         end else if (w_gap) begin
            r_shift <= '0;
            r_cnt   <= '0;
         end else if (w_valid) begin
            if (w_last) begin
               r_shift <= '0;
               r_cnt   <= '0;
               if (!r_full) begin
                  r_dout <= w_byte;
                  r_wr   <= 1'b1;
               end
            end else begin
               r_shift <= w_byte;
               r_cnt   <= r_cnt + 1'b1;
            end
         end
      end
   end

   // address moves after the strobe; the last slot sets full and holds
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_addr <= '0;
         r_len  <= '0;
         r_full <= 1'b0;
      end else if (rewind) begin
         r_addr <= '0;
         r_len  <= '0;
         r_full <= 1'b0;
      end else if (r_wr) begin
         r_len <= r_len + 1'b1;
         if (r_addr == '1)
            r_full <= 1'b1;
         else
            r_addr <= r_addr + 1'b1;
      end
   end

endmodule

// File: doc/cassette_rec.md
CASSETTE_REC -- requirements
Module: cassette_rec

Interface
REQ-001 Parameter CLK_DIV, default 57: clk cycles per 1 us timing tick (57 MHz system clock).
REQ-002 Parameter ADDR_W, default 16: record buffer address width; capacity is 2^ADDR_W bytes.
REQ-003 Parameter MIN_US, default 200: periods shorter than this are glitches.
REQ-004 Parameter THRESH_US, default 625: periods below this decode as 1 (2400 Hz), otherwise 0 (1200 Hz).
REQ-005 Parameter MAX_US, default 1500: periods longer than this are gaps.
REQ-006 clk  in  1  system clock; the only clock in the block.
REQ-007 RESET_N  in  1  reset, asynchronous, active-low.
REQ-008 cas_in  in  1  cassette output level from the CoCo sound DAC MSB; asynchronous to clk.
REQ-009 motor  in  1  cassette relay; 1 = recording enabled.
REQ-010 rewind  in  1  synchronous clear of the buffer pointer and length.
REQ-011 ram_addr  out  ADDR_W  buffer write address.
REQ-012 ram_dout  out  8  byte to write.
REQ-013 ram_wr  out  1  one-clk write strobe.
REQ-014 rec_len  out  ADDR_W+1  count of bytes written since the last rewind.
REQ-015 full  out  1  buffer exhausted.
REQ-016 active  out  1  high in state MEASURE.

Function
REQ-017 cas_in SHALL pass through a 2-flop synchronizer; a rising edge is sync==1 while the previous sync==0.
REQ-018 A prescaler SHALL emit a tick every CLK_DIV clk; us_cnt SHALL increment on each tick and saturate at MAX_US+1.
REQ-019 States are IDLE, ARM and MEASURE; reset and motor==0 force IDLE.
REQ-020 IDLE->ARM when motor==1; ARM->MEASURE on the first rising edge, with us_cnt and the prescaler cleared and no bit produced.
REQ-021 In MEASURE, a rising edge with us_cnt<MIN_US SHALL be ignored, with no restart of timing.
REQ-022 In MEASURE, a rising edge with MIN_US<=us_cnt<THRESH_US SHALL shift in bit 1; with THRESH_US<=us_cnt<=MAX_US it SHALL shift in bit 0. Both cases clear us_cnt and the prescaler.
REQ-023 Bits SHALL be assembled LSB first: the first bit after a byte boundary is bit 0.
REQ-024 When us_cnt exceeds MAX_US in MEASURE, the partial byte and the bit count SHALL be discarded and the state SHALL go to ARM, with no write.
REQ-025 On the 8th bit the byte SHALL be registered to ram_dout, and ram_wr SHALL be high exactly 1 clk, in the clk after the shift.
REQ-026 ram_addr SHALL be stable while ram_wr is high; ram_addr and rec_len SHALL increment in the clk after the strobe.
REQ-027 Motor 1->0 with 1..7 bits pending SHALL flush one write: received bits in the low positions, upper bits 0, same strobe timing as REQ-025.
REQ-028 After the write to address 2^ADDR_W-1, full SHALL be 1 and ram_addr SHALL hold; later bytes SHALL be dropped with no ram_wr.
REQ-029 rewind==1 SHALL clear ram_addr, rec_len, full, the bit count and the shift register, and SHALL suppress any ram_wr due in that clk; it has priority over all other events.
REQ-030 rewind SHALL NOT change the state, except that MEASURE->ARM.
REQ-031 An edge, a gap and a motor-off occurring in the same clk SHALL be resolved with motor-off first: flush, then IDLE, with the edge ignored.
REQ-032 All arithmetic SHALL be unsigned; no counter wraps, except the prescaler.

Reset
REQ-033 RESET_N==0 SHALL asynchronously force IDLE and set ram_addr=0, ram_dout=0, ram_wr=0, rec_len=0, full=0, active=0, us_cnt=0, prescaler=0, bit count=0 and the synchronizer flops=0.
REQ-034 Reset asserted mid-byte SHALL discard the partial byte with no write; operation resumes in IDLE on release.

Verification
REQ-035 motor=1, one arming edge, then 8 periods of 417 us -> one ram_wr, addr 0x0000, data 0xFF, rec_len=1, active=1.
REQ-036 After the arming edge, periods 417/833 alternating starting with 417 -> data 0x55 at addr 0; a second byte of 833 x8 -> 0x00 at addr 1, rec_len=2.
REQ-037 A 100 us pulse inserted between two 417 us edges, with the 417 us period measured from the last valid edge -> no extra bit; byte still 0xFF.
REQ-038 3 bits of 417 us, then a 2 ms silence, then 8 x 833 us after re-arm -> a single write of 0x00; the 3 stale bits are gone.
REQ-039 5 bits of 417 us, then motor 1->0 -> flush write 0x1F and state IDLE; with ADDR_W=4, 17 bytes give full=1 after 16, 16 strobes, rec_len=16.
REQ-040 rewind pulse in the strobe clk of byte 3, and RESET_N low mid-byte -> no write, and ram_addr=0, rec_len=0, full=0.
